// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding icache read, a single-word skid
// buffer for downstream stalls, and redirect handling that flushes in-flight reads.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_read,
    output logic [31:0] icache_address,
    input  logic [31:0] icache_rdata,
    input  logic        icache_resp,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_BUF   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state_reg,     state_next;
    logic [31:0] pc_reg,        pc_next;
    logic [31:0] target_reg,    target_next;
    logic [31:0] buf_pc_reg,    buf_pc_next;
    logic [31:0] buf_instr_reg, buf_instr_next;
    logic        valid_reg,     valid_next;
    logic [31:0] pc_o_reg,      pc_o_next;
    logic [31:0] instr_reg,     instr_next;
    logic        slot_free;

    // The read request is held steady until its response; reset masks it at once.
    assign icache_read    = !rst && ((state_reg == S_REQ) || (state_reg == S_FLUSH));
    assign icache_address = pc_reg;
    assign valid_o        = valid_reg;
    assign pc_o           = pc_o_reg;
    assign instr_o        = instr_reg;

    assign slot_free = !valid_reg || !stall_i;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        target_next    = target_reg;
        buf_pc_next    = buf_pc_reg;
        buf_instr_next = buf_instr_reg;
        valid_next     = valid_reg;
        pc_o_next      = pc_o_reg;
        instr_next     = instr_reg;

        if (redirect_i) begin
            // Redirect beats stall and response; everything in flight is dropped.
            valid_next     = 1'b0;
            buf_pc_next    = 32'd0;
            buf_instr_next = 32'd0;
            case (state_reg)
                S_BUF: begin
                    pc_next    = redirect_pc_i;
                    state_next = S_REQ;
                end
                S_REQ, S_FLUSH: begin
                    if (icache_resp) begin
                        pc_next    = redirect_pc_i;
                        state_next = S_REQ;
                    end else begin
                        // Address must not move while the read is outstanding.
                        target_next = redirect_pc_i;
                        state_next  = S_FLUSH;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (icache_resp) begin
                        pc_next = pc_reg + 32'd4;
                        if (slot_free) begin
                            valid_next = 1'b1;
                            pc_o_next  = pc_reg;
                            instr_next = icache_rdata;
                        end else begin
                            buf_pc_next    = pc_reg;
                            buf_instr_next = icache_rdata;
                            state_next     = S_BUF;
                        end
                    end else if (!stall_i) begin
                        valid_next = 1'b0;
                    end
                end
                S_BUF: begin
                    if (!stall_i) begin
                        valid_next = 1'b1;
                        pc_o_next  = buf_pc_reg;
                        instr_next = buf_instr_reg;
                        state_next = S_REQ;
                    end
                end
                S_FLUSH: begin
                    if (icache_resp) begin
                        pc_next    = target_reg;
                        state_next = S_REQ;
                    end
                    if (!stall_i) begin
                        valid_next = 1'b0;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_REQ;
            pc_reg        <= RESET_PC;
            target_reg    <= 32'd0;
            buf_pc_reg    <= 32'd0;
            buf_instr_reg <= 32'd0;
            valid_reg     <= 1'b0;
            pc_o_reg      <= 32'd0;
            instr_reg     <= 32'd0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            target_reg    <= target_next;
            buf_pc_reg    <= buf_pc_next;
            buf_instr_reg <= buf_instr_next;
            valid_reg     <= valid_next;
            pc_o_reg      <= pc_o_next;
            instr_reg     <= instr_next;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a table of per-cycle vectors with hand-computed
// outputs, followed by a long-stall skid-buffer sequence.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_read;
    logic [31:0] icache_address;
    logic [31:0] icache_rdata;
    logic        icache_resp;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;

    int errors = 0;
    int checks = 0;

    if_fetch #(.RESET_PC(32'h0000_0060)) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .valid_o        (valid_o),
        .pc_o           (pc_o),
        .instr_o        (instr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        resp;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        chk;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic rs, input logic [31:0] rd,
                                input logic st, input logic rdr, input logic [31:0] rp,
                                input logic erd, input logic [31:0] ea, input logic ev,
                                input logic ck, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.resp = rs; v.rdata = rd; v.stall = st; v.redir = rdr; v.rpc = rp;
        v.e_read = erd; v.e_addr = ea; v.e_valid = ev; v.chk = ck; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rs, input logic [31:0] rd,
                         input logic st, input logic rdr, input logic [31:0] rp);
        rst = r; icache_resp = rs; icache_rdata = rd;
        stall_i = st; redirect_i = rdr; redirect_pc_i = rp;
    endtask

    task automatic compare(input string tag, input int idx, input vec_t v);
        $display("%s %0d: rst=%0b resp=%0b stall=%0b redir=%0b -> read=%0b addr=%h valid=%0b pc=%h instr=%h",
                 tag, idx, v.rst, v.resp, v.stall, v.redir, icache_read, icache_address, valid_o, pc_o, instr_o);
        check("icache_read", idx, {31'd0, icache_read}, {31'd0, v.e_read});
        check("icache_address", idx, icache_address, v.e_addr);
        check("valid_o", idx, {31'd0, valid_o}, {31'd0, v.e_valid});
        if (v.chk) begin
            check("pc_o", idx, pc_o, v.e_pc);
            check("instr_o", idx, instr_o, v.e_instr);
        end
    endtask

    task automatic apply(input string tag, input int idx, input vec_t v);
        drive(v.rst, v.resp, v.rdata, v.stall, v.redir, v.rpc);
        @(posedge clk);
        #1;
        compare(tag, idx, v);
    endtask

    initial begin
        vec_t v;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        //             rst resp rdata          stl rdr rpc             read addr           vld chk pc_o            instr
        // reset; a response during reset is dropped
        vq.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0060, 0, 1, 32'h0,         32'h0));
        vq.push_back(mk(1, 1, 32'hDEAD_0000, 0, 0, 32'h0,         0, 32'h0000_0060, 0, 1, 32'h0,         32'h0));
        // sequential fetch 0x60, 0x64, 0x68, response two cycles after each read
        vq.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0060, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0060, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hA000_0000, 0, 0, 32'h0,         1, 32'h0000_0064, 1, 1, 32'h0000_0060, 32'hA000_0000));
        vq.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0064, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hA000_0001, 0, 0, 32'h0,         1, 32'h0000_0068, 1, 1, 32'h0000_0064, 32'hA000_0001));
        vq.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0068, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hA000_0002, 0, 0, 32'h0,         1, 32'h0000_006C, 1, 1, 32'h0000_0068, 32'hA000_0002));
        // stall with live output, response parks in the buffer
        vq.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_006C, 1, 1, 32'h0000_0068, 32'hA000_0002));
        vq.push_back(mk(0, 1, 32'hA000_0003, 1, 0, 32'h0,         0, 32'h0000_0070, 1, 1, 32'h0000_0068, 32'hA000_0002));
        vq.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_0070, 1, 1, 32'h0000_0068, 32'hA000_0002));
        vq.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0070, 1, 1, 32'h0000_006C, 32'hA000_0003));
        vq.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0070, 0, 0, 32'h0,         32'h0));
        // redirect while read outstanding: address holds, returned word discarded
        vq.push_back(mk(0, 0, 32'h0,         0, 1, 32'h0000_0200, 1, 32'h0000_0070, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0070, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hBAD0_0001, 0, 0, 32'h0,         1, 32'h0000_0200, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hB000_0000, 0, 0, 32'h0,         1, 32'h0000_0204, 1, 1, 32'h0000_0200, 32'hB000_0000));
        // redirect in the same cycle as a response
        vq.push_back(mk(0, 1, 32'hBAD0_0002, 0, 1, 32'h0000_0300, 1, 32'h0000_0300, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hC000_0000, 0, 0, 32'h0,         1, 32'h0000_0304, 1, 1, 32'h0000_0300, 32'hC000_0000));
        // redirect overrides stall; second redirect in FLUSH wins
        vq.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0400, 1, 32'h0000_0304, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 0, 32'h0,         0, 1, 32'h0000_0500, 1, 32'h0000_0304, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hBAD0_0003, 0, 0, 32'h0,         1, 32'h0000_0500, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hD000_0000, 0, 0, 32'h0,         1, 32'h0000_0504, 1, 1, 32'h0000_0500, 32'hD000_0000));
        // redirect while a word is buffered: buffered word is dropped
        vq.push_back(mk(0, 1, 32'hD000_0001, 1, 0, 32'h0,         0, 32'h0000_0508, 1, 1, 32'h0000_0500, 32'hD000_0000));
        vq.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0600, 1, 32'h0000_0600, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hE000_0000, 0, 0, 32'h0,         1, 32'h0000_0604, 1, 1, 32'h0000_0600, 32'hE000_0000));
        // reset mid-FLUSH with a response pending
        vq.push_back(mk(0, 0, 32'h0,         0, 1, 32'h0000_0700, 1, 32'h0000_0604, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(1, 1, 32'hBAD0_0004, 0, 0, 32'h0,         0, 32'h0000_0060, 0, 1, 32'h0,         32'h0));
        vq.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0060, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hF000_0000, 0, 0, 32'h0,         1, 32'h0000_0064, 1, 1, 32'h0000_0060, 32'hF000_0000));
        // pc increment wraps modulo 2^32
        vq.push_back(mk(0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0064, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'hBAD0_0005, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0));
        vq.push_back(mk(0, 1, 32'h9000_0000, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 1, 32'hFFFF_FFFC, 32'h9000_0000));

        for (int i = 0; i < vq.size(); i++) begin
            apply("vec", i, vq[i]);
        end

        // Long stall from reset: 0x60 held for five cycles while 0x64 parks.
        apply("seq", 100, mk(1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0000_0060, 0, 1, 32'h0, 32'h0));
        apply("seq", 101, mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0000_0060, 0, 0, 32'h0, 32'h0));
        apply("seq", 102, mk(0, 1, 32'h1111_0060, 0, 0, 32'h0, 1, 32'h0000_0064, 1, 1, 32'h0000_0060, 32'h1111_0060));
        apply("seq", 103, mk(0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0000_0064, 1, 1, 32'h0000_0060, 32'h1111_0060));
        apply("seq", 104, mk(0, 1, 32'h1111_0064, 1, 0, 32'h0, 0, 32'h0000_0068, 1, 1, 32'h0000_0060, 32'h1111_0060));
        for (int k = 0; k < 3; k++) begin
            apply("seq", 105 + k, mk(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0000_0068, 1, 1, 32'h0000_0060, 32'h1111_0060));
        end
        apply("seq", 108, mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0000_0068, 1, 1, 32'h0000_0064, 32'h1111_0064));
        apply("seq", 109, mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0000_0068, 0, 0, 32'h0, 32'h0));
        apply("seq", 110, mk(0, 1, 32'h1111_0068, 0, 0, 32'h0, 1, 32'h0000_006C, 1, 1, 32'h0000_0068, 32'h1111_0068));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
